// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state types shared by the alu_seq slice
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_MUL  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] OP_MUL = ALU_MUL;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle between issue and writeback
interface alu_seq_if #(
  parameter int WIDTH = 64
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       Alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  // Issuing side: drives operands and consumes results
  modport master (
    output in_valid, a, b, Alu_control, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal
  );

  // Execution unit side
  modport slave (
    input  in_valid, a, b, Alu_control, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - unsigned shift-add multiplier, one multiplier bit per cycle
module alu_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;

  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_addend;

  assign w_a_ext  = {{WIDTH{1'b0}}, i_a};
  assign w_addend = r_mplier[0] ? r_mcand : '0;

  // Start consumes multiplier bit 0 immediately so WIDTH bits finish WIDTH-1 edges later;
  // done is a one-cycle pulse and the accumulator then holds the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_acc    <= i_b[0] ? w_a_ext : '0;
        r_mcand  <= w_a_ext << 1;
        r_mplier <= i_b >> 1;
        r_cnt    <= CNT_W'(1);
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        r_acc    <= r_acc + w_addend;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered valid/ready ALU; define ALU_MUL_EN for the iterative MUL
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_overflow;
  logic               r_illegal;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_mul;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic               w_ill;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_sum    = bus.a + bus.b;
  assign w_diff   = bus.a - bus.b;
  assign w_shamt  = bus.b[SHAMT_W-1:0];
  assign w_accept = bus.in_valid && w_in_ready;

`ifdef ALU_MUL_EN
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  assign w_mul_start = w_accept && w_is_mul && !w_mul_busy;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (reset),
    .i_start   (w_mul_start),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );
`endif

  // Single-cycle operation decode; carry out of ADD/SUB is deliberately discarded
  always_comb begin
    w_res    = '0;
    w_ovf    = 1'b0;
    w_ill    = 1'b0;
    w_is_mul = 1'b0;
    case (bus.Alu_control)
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_diff;
        w_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_AND:  w_res = bus.a & bus.b;
      ALU_OR:   w_res = bus.a | bus.b;
      ALU_XOR:  w_res = bus.a ^ bus.b;
      ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      ALU_SLL:  w_res = bus.a << w_shamt;
      ALU_SRL:  w_res = bus.a >> w_shamt;
      ALU_SRA:  w_res = $signed(bus.a) >>> w_shamt;
`ifdef ALU_MUL_EN
      OP_MUL:   w_is_mul = 1'b1;
`endif
      default:  w_ill = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: only a multiply ever leaves IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept && w_is_mul) w_state_nxt = MUL;
`ifdef ALU_MUL_EN
      MUL:  if (w_mul_done) w_state_nxt = DONE;
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: accept only in IDLE with the output slot free or retiring this edge
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      IDLE:    w_in_ready = !r_out_valid || bus.out_ready;
      default: w_in_ready = 1'b0;
    endcase
  end

  // Result register: load on single-cycle accept or multiply completion, else retire
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_zero      <= (w_res == '0);
      r_overflow  <= w_ovf;
      r_illegal   <= w_ill;
`ifdef ALU_MUL_EN
    end else if (r_state == MUL && w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_prod[WIDTH-1:0];
      r_zero      <= (w_prod[WIDTH-1:0] == '0);
      r_overflow  <= |w_prod[2*WIDTH-1:WIDTH];
      r_illegal   <= 1'b0;
`endif
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_overflow;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (WIDTH=64, with or without ALU_MUL_EN)
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         il;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   seen_cyc = 0;
  int   n_out    = 0;
  bit   seen     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, wait (bounded) for acceptance, record expected result
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] res, input logic z, input logic o, input logic il,
                      input int lat, output int acc);
    exp_t e;
    bit   done = 1'b0;
    acc = -1;
    bus.Alu_control = op;
    bus.a           = a;
    bus.b           = b;
    bus.in_valid    = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (bus.in_ready === 1'b1) begin
        e.res = res; e.z = z; e.o = o; e.il = il; e.lat = lat; e.acc = cyc;
        acc = cyc;
        sb.push_back(e);
        done = 1'b1;
        @(posedge clk);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!done) chk($sformatf("accept_timeout_op%0d", op), 64'(bus.in_ready), 64'd1);
  endtask

  // Output monitor: latch first-valid cycle, pop and compare on retire
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b0 && bus.out_valid === 1'b1) begin
        if (!seen) begin
          seen     = 1'b1;
          seen_cyc = cyc;
        end
        if (bus.out_ready === 1'b1) begin
          if (sb.size() == 0) begin
            chk("spurious_out", 64'(bus.out_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("result#%0d", n_out), bus.result, e.res);
            chk($sformatf("zero#%0d", n_out), 64'(bus.zero), 64'(e.z));
            chk($sformatf("overflow#%0d", n_out), 64'(bus.overflow), 64'(e.o));
            chk($sformatf("illegal#%0d", n_out), 64'(bus.illegal), 64'(e.il));
            if (e.lat != 0) chk($sformatf("latency#%0d", n_out), 64'(seen_cyc - e.acc), 64'(e.lat));
          end
          n_out++;
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int c, c1, c2;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.Alu_control = 4'b0000;
    bus.out_ready   = 1'b1;
    reset           = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    send(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1, c);
    send(ALU_SUB, 64'd50, 64'd50, 64'd0, 1'b1, 1'b0, 1'b0, 1, c1);
    send(ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1, c2);
    chk("sub_back_to_back", 64'(c2 - c1), 64'd1);
    send(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1, c);

    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    send(ALU_XOR, 64'b1010, 64'b1100, 64'b0110, 1'b0, 1'b0, 1'b0, 1, c);
    bus.Alu_control = ALU_AND;
    bus.a           = 64'hF0;
    bus.b           = 64'h3C;
    bus.in_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("hold_result%0d", i), bus.result, 64'b0110);
      chk($sformatf("hold_valid%0d", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("hold_in_ready%0d", i), 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send(ALU_AND, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 1'b0, 1, c);

    send(ALU_SRA, 64'hF000_0000_0000_0000, 64'd68, 64'hFF00_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1, c);
    send(ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0, 1, c);
    send(ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1, c);
    send(ALU_SLL, 64'd1, 64'd65, 64'd2, 1'b0, 1'b0, 1'b0, 1, c);
    send(ALU_SRL, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 1'b0, 1'b0, 1, c);
    send(ALU_OR, 64'h0F00, 64'h00F0, 64'h0FF0, 1'b0, 1'b0, 1'b0, 1, c);
    send(4'b1111, 64'd5, 64'd6, 64'd0, 1'b1, 1'b0, 1'b1, 1, c);
    send(4'b1011, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b1, 1, c);

`ifdef ALU_MUL_EN
    send(ALU_MUL, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b1, 1'b1, 1'b0, 65, c);
    send(ALU_MUL, 64'd7, 64'd6, 64'd42, 1'b0, 1'b0, 1'b0, 65, c);
    send(ALU_MUL, 64'd3, 64'd5, 64'd15, 1'b0, 1'b0, 1'b0, 65, c);
    repeat (19) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midmul_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midmul_rst_state", 64'(dut.r_state), 64'(IDLE));
    chk("midmul_rst_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    seen = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (70) @(negedge clk);
    chk("midmul_no_partial", 64'(bus.out_valid), 64'd0);
`else
    send(4'b1010, 64'd7, 64'd6, 64'd0, 1'b1, 1'b0, 1'b1, 1, c);
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    send(ALU_OR, 64'd3, 64'd5, 64'd7, 1'b0, 1'b0, 1'b0, 1, c);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_held_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_held_result", bus.result, 64'd0);
    sb.delete();
    seen = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
`endif

    send(ALU_ADD, 64'd10, 64'd20, 64'd30, 1'b0, 1'b0, 1'b0, 1, c);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
